fcmp_arb: RTL and testbench
===========================

# fcmp_arb

Shared floating-point compare unit with a two-requester round-robin arbiter for the RV32F pipeline. It executes FLE.S, FLT.S and FEQ.S on IEEE-754 single-precision operands. It accepts one request at a time over a valid/ready handshake and returns a registered result with the RISC-V invalid (NV) flag. It also maintains a sticky NV bit that the CSR unit reads into fflags.

## Interface
- WIDTH, 32, operand/result width; the only supported value is 32.
- TAG_W, 5, opaque tag width (destination register index), returned unchanged with the response.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester i has a request.
- req0_ready / req1_ready  out  1  requester i's request is accepted this cycle.
- req0_op / req1_op  in  2  00 = FLE, 01 = FLT, 10 = FEQ, 11 = illegal.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_tag / req1_tag  in  TAG_W  tag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_src  out  1  index of the requester that issued the response.
- rsp_tag  out  TAG_W  tag of that request.
- rsp_data  out  WIDTH  compare result: 0 or 1, zero-extended.
- rsp_nv  out  1  invalid-operation flag for this response.
- fflags_clr  in  1  clear the sticky NV bit.
- fflags_nv  out  1  sticky NV bit.

## Operation
- FSM states: IDLE, EVAL, HOLD.
- IDLE:
  - Arbitrate among the asserted reqX_valid.
  - req*_ready is combinational: high only in IDLE and only for the granted requester, which must have valid high.
  - On the handshake, capture op, a, b, tag and src, update last_grant, and go to EVAL.
  - With no valid request, stay in IDLE.
- Arbitration:
  - Round-robin over a last_grant register.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester != last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- EVAL: compute the result and NV from the captured operands, register them, and go to HOLD.
- HOLD:
  - rsp_valid = 1.
  - All rsp_* outputs stay stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE.
  - No request is accepted while in HOLD.
- Compare semantics:
  - NaN means exponent 0xFF with a nonzero fraction. sNaN is a NaN with fraction[22] = 0.
  - +0 and -0 compare equal.
  - Any NaN operand gives result 0.
  - Ordered operands use sign-magnitude ordering: differing signs are decided by sign; both positive use magnitude less-than; both negative use magnitude greater-than.
  - FLE = lt | eq. FLT = lt. FEQ = eq.
- NV rules:
  - FEQ: NV = 1 iff either operand is an sNaN.
  - FLT and FLE: NV = 1 iff either operand is any NaN.
  - Illegal op (11): rsp_data = 0, rsp_nv = 0; the response is still produced with its tag.
- Sticky NV:
  - fflags_nv is set on a response handshake when rsp_nv = 1.
  - fflags_clr clears it.
  - If clear and set happen in the same cycle, set wins.
- Reset:
  - State goes to IDLE, last_grant to 1, fflags_nv to 0.
  - The captured request and any pending response are discarded.
  - Reset during EVAL or HOLD produces no response.

## Timing
- Reset values: req*_ready = 0 (while rst is high), rsp_valid = 0, rsp_src = 0, rsp_tag = 0, rsp_data = 0, rsp_nv = 0, fflags_nv = 0.
- Latency:
  - Request handshake in cycle T.
  - EVAL in cycle T+1.
  - rsp_valid high from cycle T+2.
- Throughput: one operation per 3 cycles when rsp_ready is held high. A new request can be accepted in the cycle after the response handshake.
- rsp_ready low holds the block in HOLD indefinitely; rsp_* outputs must not change while stalled.
- fflags_nv updates in the cycle after the response handshake.
- The req*_ready paths are combinational from req*_valid and state; no other input-to-output combinational paths exist.

## Test plan
- Basic compares:
  - FLE a=0x3F800000, b=0x40000000 → rsp_data = 1, rsp_nv = 0, rsp_valid two cycles after accept.
  - FLT -2.0 (0xC0000000) vs -1.0 (0xBF800000) → 1.
- Signed zero: FEQ 0x80000000 vs 0x00000000 → 1. FLT on the same pair → 0. FLE on the same pair → 1.
- NaN flags:
  - FEQ qNaN 0x7FC00000 vs 1.0 → data 0, nv 0.
  - FEQ sNaN 0x7F800001 vs 1.0 → data 0, nv 1.
  - FLT qNaN vs 1.0 → data 0, nv 1, and fflags_nv = 1 afterwards.
  - fflags_clr pulsed in the same cycle as an nv = 1 response handshake → fflags_nv stays 1.
- Arbitration: both requesters continuously valid with tags 0/1, 6 requests → rsp_src sequence 0,1,0,1,0,1. A requester valid alone is granted regardless of last_grant.
- Backpressure: rsp_ready held low for 5 cycles in HOLD → rsp_* stable, req*_ready = 0 throughout. The response completes on the first cycle rsp_ready = 1.
- Reset mid-operation: rst asserted during EVAL → no rsp_valid afterwards, all outputs 0. The next tie after reset is granted to requester 0.

Source files
------------

// File: rtl/fcmp_arb_if.sv
// Request/response bundle for the shared FP compare unit: two requesters,
// one response channel and the sticky NV flag.
interface fcmp_arb_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_nv;

    logic             fflags_clr;
    logic             fflags_nv;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_src, rsp_tag, rsp_data, rsp_nv,
        output rsp_ready, fflags_clr,
        input  fflags_nv
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_src, rsp_tag, rsp_data, rsp_nv,
        input  rsp_ready, fflags_clr,
        output fflags_nv
    );
endinterface

// File: rtl/fcmp_arb.sv
// Shared single-precision FLE/FLT/FEQ unit with a two-way round-robin
// arbiter, registered response (accept -> eval -> hold) and sticky NV.
module fcmp_arb #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    fcmp_arb_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] tag_q;
    logic             src_q;

    logic             rsp_valid_q;
    logic             rsp_src_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_res_q;
    logic             rsp_nv_q;
    logic             fflags_nv_q;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic             grant_d;
    logic             accept;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    // On a tie the requester that did not win last time gets the slot.
    assign grant_d   = (&req_valid) ? ~last_grant_q : req_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == IDLE) && !rst && req_valid[gi]
                                   && (grant_d == 1'(gi));
        end
    endgenerate

    assign accept         = |req_ready;
    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    logic a_nan, b_nan, a_snan, b_snan, any_nan, both_zero;
    logic eq_d, lt_d, res_d, nv_d;

    always_comb begin
        a_nan     = (&a_q[30:23]) && (|a_q[22:0]);
        b_nan     = (&b_q[30:23]) && (|b_q[22:0]);
        a_snan    = a_nan && !a_q[22];
        b_snan    = b_nan && !b_q[22];
        any_nan   = a_nan || b_nan;
        both_zero = (a_q[30:0] == 31'd0) && (b_q[30:0] == 31'd0);
        eq_d      = !any_nan && ((a_q == b_q) || both_zero);
        lt_d      = 1'b0;
        if (!any_nan) begin
            if (a_q[31] != b_q[31]) begin
                lt_d = a_q[31] && !both_zero;
            end else if (!a_q[31]) begin
                lt_d = a_q[30:0] < b_q[30:0];
            end else begin
                lt_d = a_q[30:0] > b_q[30:0];
            end
        end
        res_d = 1'b0;
        nv_d  = 1'b0;
        case (op_q)
            2'b00: begin res_d = lt_d | eq_d; nv_d = any_nan;          end
            2'b01: begin res_d = lt_d;        nv_d = any_nan;          end
            2'b10: begin res_d = eq_d;        nv_d = a_snan || b_snan; end
            default: begin res_d = 1'b0;      nv_d = 1'b0;             end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_src_q    <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_res_q    <= 1'b0;
            rsp_nv_q     <= 1'b0;
            fflags_nv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q         <= grant_d ? bus.req1_op  : bus.req0_op;
                        a_q          <= grant_d ? bus.req1_a   : bus.req0_a;
                        b_q          <= grant_d ? bus.req1_b   : bus.req0_b;
                        tag_q        <= grant_d ? bus.req1_tag : bus.req0_tag;
                        src_q        <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_src_q   <= src_q;
                    rsp_tag_q   <= tag_q;
                    rsp_res_q   <= res_d;
                    rsp_nv_q    <= nv_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A set from a flagged handshake overrides a simultaneous clear.
            if ((state_q == HOLD) && bus.rsp_ready && rsp_nv_q) begin
                fflags_nv_q <= 1'b1;
            end else if (bus.fflags_clr) begin
                fflags_nv_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_src   = rsp_src_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = {{(WIDTH-1){1'b0}}, rsp_res_q};
    assign bus.rsp_nv    = rsp_nv_q;
    assign bus.fflags_nv = fflags_nv_q;
endmodule

// File: tb/tb_fcmp_arb.sv
// Scoreboard bench for fcmp_arb: driver predicts grant/result from an
// ordered-key model and queues it; a monitor checks each presented response.
module tb_fcmp_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fcmp_arb_if #(.WIDTH(32), .TAG_W(5)) bus();
    fcmp_arb #(.WIDTH(32), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit       src;
        bit [4:0] tag;
        bit       data;
        bit       nv;
        int       acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ncyc     = 0;
    bit   lg_m     = 1'b1;
    bit   sticky_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps ordered floats onto a signed integer line; +0 and -0 both map to 0.
    function automatic longint fkey(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic void ref_cmp(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output bit d, output bit nv);
        bit nan, snan, lt, eq;
        nan  = is_nan(a) || is_nan(b);
        snan = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
        lt   = !nan && (fkey(a) < fkey(b));
        eq   = !nan && (fkey(a) == fkey(b));
        case (op)
            2'd0:    begin d = lt || eq; nv = nan;  end
            2'd1:    begin d = lt;       nv = nan;  end
            2'd2:    begin d = eq;       nv = snan; end
            default: begin d = 1'b0;     nv = 1'b0; end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 13)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'hBF80_0000;
            4: return 32'h4000_0000;
            5: return 32'hC000_0000;
            6: return 32'h7F80_0000;
            7: return 32'hFF80_0000;
            8: return 32'h7FC0_0000;
            9: return 32'h7F80_0001;
            10: return 32'hFFA0_0000;
            11: return {1'b0, 8'd127, 23'($urandom)};
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every rising rsp_valid must match the oldest queued expectation.
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (bus.rsp_valid && !prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_src", bus.rsp_src, e.src);
                    chk("rsp_tag", bus.rsp_tag, e.tag);
                    chk("rsp_data", bus.rsp_data, {31'd0, e.data});
                    chk("rsp_nv", bus.rsp_nv, e.nv);
                    chk("latency", ncyc - e.acc, 2);
                    $display("RSP src=%0d tag=%0d data=%0d nv=%0d", bus.rsp_src,
                             bus.rsp_tag, bus.rsp_data, bus.rsp_nv);
                end
            end
            prev = bus.rsp_valid;
        end
    end

    task automatic txn(input bit v0, input bit v1,
                       input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [4:0] t0,
                       input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [4:0] t1, input int stall, input bit clr);
        bit w, d, nv;
        logic [38:0] snap;
        exp_t e;
        @(negedge clk); #1;
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_tag = t1;
        bus.rsp_ready = 1'b0;
        w = (v0 && v1) ? !lg_m : v1;
        #1;
        chk("req0_ready", bus.req0_ready, v0 && !w);
        chk("req1_ready", bus.req1_ready, v1 && w);
        if (w) ref_cmp(op1, a1, b1, d, nv);
        else   ref_cmp(op0, a0, b0, d, nv);
        e = '{src: w, tag: (w ? t1 : t0), data: d, nv: nv, acc: ncyc};
        sb.push_back(e);
        lg_m = w;
        $display("TXN src=%0d op=%0d a=%h b=%h tag=%0d stall=%0d clr=%0d", w,
                 w ? op1 : op0, w ? a1 : a0, w ? b1 : b0, w ? t1 : t0, stall, clr);
        @(negedge clk); #1;
        chk("eval_ready", {bus.req0_ready, bus.req1_ready}, 0);
        chk("eval_valid", bus.rsp_valid, 0);
        @(negedge clk); #1;
        snap = {bus.rsp_src, bus.rsp_tag, bus.rsp_data, bus.rsp_nv};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            chk("hold_ready", {bus.req0_ready, bus.req1_ready}, 0);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_stable", {bus.rsp_src, bus.rsp_tag, bus.rsp_data, bus.rsp_nv}, snap);
        end
        bus.rsp_ready  = 1'b1;
        bus.fflags_clr = clr;
        @(posedge clk); #1;
        bus.rsp_ready  = 1'b0;
        bus.fflags_clr = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        sticky_m = nv ? 1'b1 : (clr ? 1'b0 : sticky_m);
        chk("post_valid", bus.rsp_valid, 0);
        chk("fflags_nv", bus.fflags_nv, sticky_m);
    endtask

    task automatic single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int stall, input bit clr);
        txn(1'b1, 1'b0, op, a, b, tag, 2'd0, 32'd0, 32'd0, 5'd0, stall, clr);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_ready0"}, bus.req0_ready, 0);
        chk({tagname, "_ready1"}, bus.req1_ready, 0);
        chk({tagname, "_valid"}, bus.rsp_valid, 0);
        chk({tagname, "_src"}, bus.rsp_src, 0);
        chk({tagname, "_tag"}, bus.rsp_tag, 0);
        chk({tagname, "_data"}, bus.rsp_data, 0);
        chk({tagname, "_nv"}, bus.rsp_nv, 0);
        chk({tagname, "_fflags"}, bus.fflags_nv, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'd0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'd0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
        bus.rsp_ready = 1'b0;
        bus.fflags_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        single(2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd1, 0, 1'b0);
        single(2'd1, 32'hC000_0000, 32'hBF80_0000, 5'd2, 0, 1'b0);
        single(2'd2, 32'h8000_0000, 32'h0000_0000, 5'd3, 0, 1'b0);
        single(2'd1, 32'h8000_0000, 32'h0000_0000, 5'd4, 1, 1'b0);
        single(2'd0, 32'h8000_0000, 32'h0000_0000, 5'd5, 0, 1'b0);
        single(2'd2, 32'h7FC0_0000, 32'h3F80_0000, 5'd6, 0, 1'b0);
        single(2'd2, 32'h7F80_0001, 32'h3F80_0000, 5'd7, 0, 1'b0);
        single(2'd1, 32'h7FC0_0000, 32'h3F80_0000, 5'd8, 0, 1'b0);
        single(2'd0, 32'h4000_0000, 32'h3F80_0000, 5'd9, 0, 1'b1);
        single(2'd0, 32'h7FC0_0000, 32'h3F80_0000, 5'd10, 0, 1'b1);
        single(2'd2, 32'h3F80_0000, 32'h3F80_0000, 5'd11, 2, 1'b1);
        single(2'd3, 32'h7F80_0001, 32'h3F80_0000, 5'd12, 0, 1'b0);
        single(2'd1, 32'h3F80_0000, 32'h4000_0000, 5'd13, 5, 1'b0);

        // Reset while the captured request is being evaluated.
        @(negedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'd1; bus.req0_a = 32'h7FC0_0000;
        bus.req0_b = 32'h3F80_0000; bus.req0_tag = 5'd20;
        @(negedge clk); #1;
        rst = 1'b1;
        bus.req1_valid = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        @(negedge clk); #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lg_m = 1'b1;
        sticky_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("postrst_valid", bus.rsp_valid, 0);
        end

        for (int i = 0; i < 6; i++) begin
            txn(1'b1, 1'b1, 2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd0,
                2'd1, 32'h4000_0000, 32'h3F80_0000, 5'd1, 0, 1'b0);
        end
        txn(1'b0, 1'b1, 2'd2, 32'd0, 32'd0, 5'd0, 2'd2, 32'h8000_0000, 32'h0, 5'd21, 0, 1'b0);
        single(2'd0, 32'hFF80_0000, 32'h7F80_0000, 5'd22, 0, 1'b0);
        single(2'd0, 32'h7F80_0000, 32'hFF80_0000, 5'd23, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int  v;
            logic [31:0] x0, x1;
            v  = int'($urandom_range(1, 3));
            x0 = pick();
            x1 = pick();
            txn(v[0], v[1],
                2'($urandom), x0, (($urandom % 5) == 0) ? x0 : pick(), 5'($urandom),
                2'($urandom), x1, pick(), 5'($urandom),
                int'($urandom_range(0, 3)), (($urandom % 4) == 0));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
